// File: rtl/cnn_pkg.sv
// Shared CNN constants and the image-loader state type.
package cnn_pkg;

  localparam int N_PIX      = 784;
  localparam int PIX_ADDR_W = 10;
  localparam int BYTE_W     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } loader_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO with wrap-bit pointers; the head entry is read combinationally.
module byte_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  // A push into a full FIFO is still taken when the head leaves on the same edge.
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clr) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/img_loader.sv
// Unpacks received bytes LSB-first into one-word pixels for the CNN input RAM.
// Optional mid-frame idle timeout enabled with IMG_LOADER_TIMEOUT_EN.
module img_loader #(
  parameter int N_PIX      = cnn_pkg::N_PIX,
  parameter int FIFO_DEPTH = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [cnn_pkg::BYTE_W-1:0]    rx_data,
  input  logic                          rx_rdy,
  input  logic                          core_busy,
  output logic                          wr_en,
  output logic [cnn_pkg::PIX_ADDR_W-1:0] wr_addr,
  output logic [1:0]                    wr_data,
  output logic                          img_rdy,
  output logic                          ovf,
  output logic                          frame_err
);
  import cnn_pkg::*;

  // state | meaning
  // IDLE  | waiting for a byte and core_busy=0
  // SHIFT | writing one pixel per cycle from the shift register
  // DONE  | frame complete, img_rdy pulse

  loader_state_t          state;
  logic [BYTE_W-1:0]      sh;
  logic [2:0]             bit_cnt;
  logic [PIX_ADDR_W-1:0]  pix_cnt;
  logic [BYTE_W-1:0]      fifo_dout;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_pop;
  logic                   last_pix;
  logic                   timeout_hit;

  byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(BYTE_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (timeout_hit),
    .push  (rx_rdy),
    .pop   (fifo_pop),
    .din   (rx_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign last_pix = (pix_cnt == PIX_ADDR_W'(N_PIX - 1));

  always_comb begin
    fifo_pop = 1'b0;
    if (!timeout_hit && !fifo_empty) begin
      if (state == IDLE)
        fifo_pop = !core_busy;
      else if (state == SHIFT && bit_cnt == 3'd7)
        fifo_pop = !last_pix;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sh      <= '0;
      bit_cnt <= '0;
      pix_cnt <= '0;
    end else if (timeout_hit) begin
      state   <= IDLE;
      bit_cnt <= '0;
      pix_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_pop) begin
            sh      <= fifo_dout;
            bit_cnt <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          sh      <= sh >> 1;
          bit_cnt <= bit_cnt + 3'd1;
          pix_cnt <= pix_cnt + PIX_ADDR_W'(1);
          if (bit_cnt == 3'd7) begin
            // bit_cnt wraps to 0 on its own, so a back-to-back reload needs no bubble
            if (last_pix)
              state <= DONE;
            else if (fifo_pop)
              sh <= fifo_dout;
            else
              state <= IDLE;
          end
        end
        DONE: begin
          pix_cnt <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf <= 1'b0;
    else if (rx_rdy && fifo_full && !fifo_pop)
      ovf <= 1'b1;
  end

  assign wr_en   = (state == SHIFT);
  assign wr_addr = pix_cnt;
  assign wr_data = wr_en ? {2{sh[0]}} : 2'b00;
  assign img_rdy = (state == DONE);

`ifdef IMG_LOADER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] idle_cnt;
  logic            frame_active;
  logic            frame_err_q;

  assign frame_active = (pix_cnt != '0) || !fifo_empty;
  assign timeout_hit  = frame_active && !rx_rdy && (idle_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt    <= TO_W'(TIMEOUT - 1);
      frame_err_q <= 1'b0;
    end else begin
      if (rx_rdy || !frame_active || timeout_hit)
        idle_cnt <= TO_W'(TIMEOUT - 1);
      else
        idle_cnt <= idle_cnt - TO_W'(1);
      if (timeout_hit)
        frame_err_q <= 1'b1;
    end
  end

  assign frame_err = frame_err_q;
`else
  assign timeout_hit = 1'b0;
  assign frame_err   = 1'b0;
`endif

endmodule

// File: tb/tb_img_loader.sv
// Scenario bench for img_loader: expected pixel writes are queued as bytes are sent.
module tb_img_loader;

  localparam int NP = 784;
  localparam int NB = 98;
`ifdef IMG_LOADER_TIMEOUT_EN
  localparam int GAP = 9;
`else
  localparam int GAP = 6;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       core_busy;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [1:0] wr_data;
  logic       img_rdy;
  logic       ovf;
  logic       frame_err;

  img_loader #(.N_PIX(NP), .FIFO_DEPTH(32), .TIMEOUT(100)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_rdy    (rx_rdy),
    .core_busy (core_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .img_rdy   (img_rdy),
    .ovf       (ovf),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] addr;
    logic [1:0] data;
  } pix_t;

  pix_t act_q[$];
  pix_t exp_q[$];
  int   cyc = 0;
  int   rdy_cnt, rdy_t, rdy_with_wr, busy_wr;
  int   first_wr_t, last_wr_t, last_push_t;
  int   exp_pix;
  int   n_pass = 0;
  int   n_total = 0;
  logic [7:0] frame [NB];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (wr_en) begin
        if (act_q.size() == 0) first_wr_t = cyc;
        last_wr_t = cyc;
        act_q.push_back('{addr: wr_addr, data: wr_data});
      end
      if (img_rdy) begin
        rdy_cnt++;
        rdy_t = cyc;
        if (wr_en) rdy_with_wr++;
      end
      if (wr_en && core_busy) busy_wr++;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    @(posedge clk);
    #1;
    act_q.delete();
    exp_q.delete();
    rdy_cnt = 0;
    rdy_with_wr = 0;
    busy_wr = 0;
    exp_pix = 0;
  endtask

  task automatic queue_exp(input logic [7:0] b);
    for (int i = 0; i < 8; i++)
      exp_q.push_back('{addr: 10'(exp_pix + i), data: {2{b[i]}}});
    exp_pix = (exp_pix + 8) % NP;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_data = b;
    rx_rdy = 1'b1;
    last_push_t = cyc;
    queue_exp(b);
    @(negedge clk);
    rx_rdy = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic send_frame(input int first, input int last, input int gap);
    for (int i = first; i <= last; i++) send_byte(frame[i], gap);
  endtask

  task automatic wait_writes(input int n, input int budget);
    int b;
    b = budget;
    while (act_q.size() < n && b > 0) begin
      @(negedge clk);
      b--;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_total++; if (wr_en !== 1'b0) $display("FAIL rst_wr_en got %b want 0", wr_en); else n_pass++;
    n_total++; if (wr_addr !== 10'd0) $display("FAIL rst_wr_addr got %0d want 0", wr_addr); else n_pass++;
    n_total++; if (wr_data !== 2'd0) $display("FAIL rst_wr_data got %0d want 0", wr_data); else n_pass++;
    n_total++; if (img_rdy !== 1'b0) $display("FAIL rst_img_rdy got %b want 0", img_rdy); else n_pass++;
    n_total++; if (ovf !== 1'b0) $display("FAIL rst_ovf got %b want 0", ovf); else n_pass++;
    n_total++; if (frame_err !== 1'b0) $display("FAIL rst_frame_err got %b want 0", frame_err); else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_byte();
    logic [1:0] a5_pix [8];
    int t0, n;
    pix_t a, e;
    a5_pix = '{2'd3, 2'd0, 2'd3, 2'd0, 2'd0, 2'd3, 2'd0, 2'd3};
    clear_mon();
    send_byte(8'hA5, GAP);
    t0 = last_push_t;
    wait_writes(8, 50);
    n_total++; if (act_q.size() < 8) $display("FAIL a5_count got %0d want >=8", act_q.size()); else n_pass++;
    n_total++; if (first_wr_t - t0 != 2) $display("FAIL a5_latency got %0d want 2", first_wr_t - t0); else n_pass++;
    for (int i = 0; i < 8 && i < act_q.size(); i++) begin
      n_total++;
      if (act_q[i].addr !== 10'(i) || act_q[i].data !== a5_pix[i])
        $display("FAIL a5_pix[%0d] got a=%0d d=%0d want a=%0d d=%0d", i, act_q[i].addr, act_q[i].data, i, a5_pix[i]);
      else n_pass++;
    end
    send_frame(1, NB - 1, GAP);
    wait_writes(NP, 2000);
    n_total++; if (act_q.size() != NP) $display("FAIL frame1_count got %0d want %0d", act_q.size(), NP); else n_pass++;
    n = 0;
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front();
      e = exp_q.pop_front();
      n_total++;
      if (a !== e) $display("FAIL frame1_pix[%0d] got a=%0d d=%0d want a=%0d d=%0d", n, a.addr, a.data, e.addr, e.data);
      else n_pass++;
      n++;
    end
    n_total++; if (rdy_cnt != 1) $display("FAIL frame1_img_rdy_count got %0d want 1", rdy_cnt); else n_pass++;
    n_total++; if (rdy_t != last_wr_t + 1) $display("FAIL frame1_img_rdy_time got %0d want %0d", rdy_t, last_wr_t + 1); else n_pass++;
    n_total++; if (rdy_with_wr != 0) $display("FAIL frame1_rdy_with_wr got %0d want 0", rdy_with_wr); else n_pass++;
    n_total++; if (ovf !== 1'b0) $display("FAIL frame1_ovf got %b want 0", ovf); else n_pass++;
  endtask

  task automatic test_core_busy();
    int n;
    pix_t a, e;
    clear_mon();
    core_busy = 1'b1;
    send_frame(0, 27, GAP);
    repeat (20) @(negedge clk);
    n_total++; if (act_q.size() != 0) $display("FAIL busy_hold_writes got %0d want 0", act_q.size()); else n_pass++;
    n_total++; if (ovf !== 1'b0) $display("FAIL busy_hold_ovf got %b want 0", ovf); else n_pass++;
    core_busy = 1'b0;
    send_frame(28, NB - 1, 12);
    wait_writes(NP, 2000);
    n_total++; if (act_q.size() != NP) $display("FAIL busy_count got %0d want %0d", act_q.size(), NP); else n_pass++;
    n = 0;
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front();
      e = exp_q.pop_front();
      n_total++;
      if (a !== e) $display("FAIL busy_pix[%0d] got a=%0d d=%0d want a=%0d d=%0d", n, a.addr, a.data, e.addr, e.data);
      else n_pass++;
      n++;
    end
    n_total++; if (busy_wr != 0) $display("FAIL busy_wr_en got %0d want 0", busy_wr); else n_pass++;
    n_total++; if (rdy_cnt != 1) $display("FAIL busy_img_rdy_count got %0d want 1", rdy_cnt); else n_pass++;
    n_total++; if (ovf !== 1'b0) $display("FAIL busy_ovf got %b want 0", ovf); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int n;
    pix_t a, e;
    clear_mon();
    @(negedge clk);
    rx_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rx_data = frame[i];
      queue_exp(frame[i]);
      @(negedge clk);
    end
    rx_rdy = 1'b0;
    repeat (600) @(negedge clk);
`ifndef IMG_LOADER_TIMEOUT_EN
    // 32 stored plus 5 popped during the burst: the last 3 bytes are dropped
    n_total++; if (act_q.size() != 296) $display("FAIL b2b_count got %0d want 296", act_q.size()); else n_pass++;
`endif
    n_total++; if (ovf !== 1'b1) $display("FAIL b2b_ovf got %b want 1", ovf); else n_pass++;
    n_total++; if (rdy_cnt != 0) $display("FAIL b2b_img_rdy got %0d want 0", rdy_cnt); else n_pass++;
    n_total++; if (wr_en !== 1'b0) $display("FAIL b2b_drained_wr_en got %b want 0", wr_en); else n_pass++;
    n = 0;
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front();
      e = exp_q.pop_front();
      n_total++;
      if (a !== e) $display("FAIL b2b_pix[%0d] got a=%0d d=%0d want a=%0d d=%0d", n, a.addr, a.data, e.addr, e.data);
      else n_pass++;
      n++;
    end
  endtask

  task automatic test_reset_mid_frame();
    int n, b;
    pix_t a, e;
    pulse_reset();
    clear_mon();
    send_frame(0, 49, GAP);
    b = 50;
    @(negedge clk);
    while (wr_en !== 1'b1 && b > 0) begin
      @(negedge clk);
      b--;
    end
    n_total++; if (wr_en !== 1'b1) $display("FAIL rstmid_busy got wr_en=%b want 1", wr_en); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++; if (wr_en !== 1'b0) $display("FAIL rstmid_wr_en got %b want 0", wr_en); else n_pass++;
    n_total++; if (wr_addr !== 10'd0) $display("FAIL rstmid_wr_addr got %0d want 0", wr_addr); else n_pass++;
    n_total++; if (wr_data !== 2'd0) $display("FAIL rstmid_wr_data got %0d want 0", wr_data); else n_pass++;
    n_total++; if (img_rdy !== 1'b0) $display("FAIL rstmid_img_rdy got %b want 0", img_rdy); else n_pass++;
    n_total++; if (ovf !== 1'b0) $display("FAIL rstmid_ovf got %b want 0", ovf); else n_pass++;
    n_total++; if (rdy_cnt != 0) $display("FAIL rstmid_partial_rdy got %0d want 0", rdy_cnt); else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    send_frame(0, NB - 1, GAP);
    wait_writes(NP, 2000);
    n_total++; if (act_q.size() != NP) $display("FAIL rstmid_count got %0d want %0d", act_q.size(), NP); else n_pass++;
    n = 0;
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front();
      e = exp_q.pop_front();
      n_total++;
      if (a !== e) $display("FAIL rstmid_pix[%0d] got a=%0d d=%0d want a=%0d d=%0d", n, a.addr, a.data, e.addr, e.data);
      else n_pass++;
      n++;
    end
    n_total++; if (rdy_cnt != 1) $display("FAIL rstmid_img_rdy got %0d want 1", rdy_cnt); else n_pass++;
  endtask

  task automatic test_timeout();
    int n;
    pix_t a, e;
    clear_mon();
    send_frame(0, 9, GAP);
    repeat (300) @(negedge clk);
    n_total++; if (act_q.size() != 80) $display("FAIL to_partial_count got %0d want 80", act_q.size()); else n_pass++;
    n_total++; if (rdy_cnt != 0) $display("FAIL to_img_rdy got %0d want 0", rdy_cnt); else n_pass++;
`ifdef IMG_LOADER_TIMEOUT_EN
    n_total++; if (frame_err !== 1'b1) $display("FAIL to_frame_err got %b want 1", frame_err); else n_pass++;
    clear_mon();
    send_frame(0, NB - 1, GAP);
`else
    n_total++; if (frame_err !== 1'b0) $display("FAIL to_frame_err got %b want 0", frame_err); else n_pass++;
    send_frame(10, NB - 1, GAP);
`endif
    wait_writes(NP, 2000);
    n_total++; if (act_q.size() != NP) $display("FAIL to_next_count got %0d want %0d", act_q.size(), NP); else n_pass++;
    n = 0;
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front();
      e = exp_q.pop_front();
      n_total++;
      if (a !== e) $display("FAIL to_next_pix[%0d] got a=%0d d=%0d want a=%0d d=%0d", n, a.addr, a.data, e.addr, e.data);
      else n_pass++;
      n++;
    end
    n_total++; if (rdy_cnt != 1) $display("FAIL to_next_img_rdy got %0d want 1", rdy_cnt); else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    rx_rdy = 1'b0;
    rx_data = 8'h00;
    core_busy = 1'b0;
    for (int i = 0; i < NB; i++) frame[i] = 8'($urandom);
    test_reset();
    test_single_byte();
    test_core_busy();
    test_back_to_back();
    test_reset_mid_frame();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
